// File: rtl/bcd_mmss_counter.sv
// bcd_mmss_counter
// Minutes:seconds BCD time counter clocked by the fast system clock.
// The divider's slow square wave arrives as asynchronous data on slow_i. It is
// synchronised, then edge-detected into one-cycle second ticks that advance a
// 4-digit BCD mm:ss value.
// Optional build macro LAP_CAPTURE_EN adds a lap input and a 16-bit lap_q
// snapshot of the digits.
// Legal parameter ranges: SYNC_STAGES 2..4, MIN_LIMIT 2..100.

module bcd_mmss_counter #(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_LIMIT   = 60
) (
   input  logic        clki,
   input  logic        rst,
   input  logic        slow_i,
   input  logic        en,
   input  logic        clr,
   input  logic        inc_min,
   output logic [3:0]  sec_ones,
   output logic [3:0]  sec_tens,
   output logic [3:0]  min_ones,
   output logic [3:0]  min_tens,
   output logic        tick_o,
   output logic        wrap_o
`ifdef LAP_CAPTURE_EN
   ,
   input  logic        lap,
   output logic [15:0] lap_q
`endif
);

   // Ticks stay masked until the synchroniser has flushed the values it held
   // at reset, so a slow_i that is already high at release gives no tick.
   localparam int         PRIME_CYCLES  = SYNC_STAGES + 1;
   localparam logic [2:0] LP_PRIME_DONE = 3'(PRIME_CYCLES);
   localparam logic [7:0] LP_LIMIT      = 8'(MIN_LIMIT);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_edge;
   logic [2:0]             r_prime;
   logic                   r_tick;
   logic                   r_wrap;
   logic [3:0]             r_sec_ones;
   logic [3:0]             r_sec_tens;
   logic [3:0]             r_min_ones;
   logic [3:0]             r_min_tens;

   logic                   w_synced;
   logic                   w_rise;
   logic                   w_tick;
   logic                   w_step;
   logic                   w_sec_carry;
   logic [3:0]             w_sec_ones_next;
   logic [3:0]             w_sec_tens_next;
   logic [7:0]             w_min_val;
   logic [7:0]             w_min_sum;
   logic                   w_min_over;
   logic [7:0]             w_min_next;
   logic [3:0]             w_min_ones_next;
   logic [3:0]             w_min_tens_next;
   logic                   w_wrap;

   assign w_synced = r_sync[SYNC_STAGES-1];
   assign w_rise   = w_synced & ~r_edge;
   assign w_tick   = w_rise & (r_prime == LP_PRIME_DONE);
   assign w_step   = w_tick & en;

   // Synchroniser chain, edge register and priming counter
   always_ff @(posedge clki) begin
      // NOTE: reset is sampled on the clock edge like any other input; the
      // reset branch therefore sits inside the clocked block, not its sensitivity list.
      if (rst) begin
         // NOTE: state is written with <= so every flop samples pre-edge values
         // and the shift chain cannot collapse into a single stage.
         r_sync  <= '0;
         r_edge  <= 1'b0;
         r_prime <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], slow_i};
         r_edge <= w_synced;
         if (r_prime != LP_PRIME_DONE) begin
            r_prime <= r_prime + 3'd1;
         end
      end
   end

   // Seconds next-state with carry into the minutes
   always_comb begin
      // NOTE: every output gets a default first, so no path through the block
      // can leave a value unassigned and infer a latch.
      w_sec_ones_next = r_sec_ones;
      w_sec_tens_next = r_sec_tens;
      w_sec_carry     = 1'b0;
      if (w_step) begin
         if (r_sec_ones == 4'd9) begin
            w_sec_ones_next = 4'd0;
            if (r_sec_tens == 4'd5) begin
               w_sec_tens_next = 4'd0;
               w_sec_carry     = 1'b1;
            end else begin
               w_sec_tens_next = r_sec_tens + 4'd1;
            end
         end else begin
            w_sec_ones_next = r_sec_ones + 4'd1;
         end
      end
   end

   // Minutes are advanced as a binary value by 0..2 and re-encoded. The sum
   // never exceeds MIN_LIMIT+1, so a single conditional subtract is the modulus.
   assign w_min_val       = 8'(r_min_tens) * 8'd10 + 8'(r_min_ones);
   assign w_min_sum       = w_min_val + 8'(w_sec_carry) + 8'(inc_min);
   assign w_min_over      = (w_min_sum >= LP_LIMIT);
   assign w_min_next      = w_min_over ? (w_min_sum - LP_LIMIT) : w_min_sum;
   assign w_min_tens_next = 4'(w_min_next / 8'd10);
   assign w_min_ones_next = 4'(w_min_next % 8'd10);

   // A wrap is reported only when the seconds carry takes part in crossing zero;
   // a wrap caused by inc_min alone is a time-set action, not elapsed time.
   assign w_wrap = w_sec_carry & w_min_over;

   // Tick and wrap pulses; clr masks wrap but leaves tick visible
   always_ff @(posedge clki) begin
      if (rst) begin
         r_tick <= 1'b0;
         r_wrap <= 1'b0;
      end else begin
         r_tick <= w_tick;
         r_wrap <= w_wrap & ~clr;
      end
   end

   // Digit registers: clr beats counting and inc_min
   always_ff @(posedge clki) begin
      if (rst || clr) begin
         r_sec_ones <= 4'd0;
         r_sec_tens <= 4'd0;
         r_min_ones <= 4'd0;
         r_min_tens <= 4'd0;
      end else begin
         r_sec_ones <= w_sec_ones_next;
         r_sec_tens <= w_sec_tens_next;
         r_min_ones <= w_min_ones_next;
         r_min_tens <= w_min_tens_next;
      end
   end

   assign sec_ones = r_sec_ones;
   assign sec_tens = r_sec_tens;
   assign min_ones = r_min_ones;
   assign min_tens = r_min_tens;
   assign tick_o   = r_tick;
   assign wrap_o   = r_wrap;

`ifdef LAP_CAPTURE_EN
   logic [15:0] r_lap;

   // Lap snapshot of the pre-update digits; unaffected by clr
   always_ff @(posedge clki) begin
      if (rst) begin
         r_lap <= 16'h0000;
      end else if (lap) begin
         r_lap <= {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones};
      end
   end

   assign lap_q = r_lap;
`endif

endmodule

// File: tb/tb_bcd_mmss_counter.sv
// tb_bcd_mmss_counter
// Directed bench with a scoreboard: each issued second pulse pushes the
// expected digits, wrap flag and due cycle; a monitor pops on every tick_o.
// Build with LAP_CAPTURE_EN defined to cover the lap ports as well.

module tb_bcd_mmss_counter;

   logic        clki;
   logic        rst;
   logic        slow_i;
   logic        en;
   logic        clr;
   logic        inc_min;
   logic [3:0]  sec_ones;
   logic [3:0]  sec_tens;
   logic [3:0]  min_ones;
   logic [3:0]  min_tens;
   logic        tick_o;
   logic        wrap_o;
`ifdef LAP_CAPTURE_EN
   logic        lap;
   logic [15:0] lap_q;
`endif

   typedef struct {
      logic [15:0] bcd;
      logic        wrap;
      int          due;
   } exp_t;

   exp_t q_exp[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_ticks  = 0;
   int   cyc      = 0;

   bcd_mmss_counter #(
      .SYNC_STAGES(2),
      .MIN_LIMIT  (60)
   ) dut (
      .clki    (clki),
      .rst     (rst),
      .slow_i  (slow_i),
      .en      (en),
      .clr     (clr),
      .inc_min (inc_min),
      .sec_ones(sec_ones),
      .sec_tens(sec_tens),
      .min_ones(min_ones),
      .min_tens(min_tens),
      .tick_o  (tick_o),
      .wrap_o  (wrap_o)
`ifdef LAP_CAPTURE_EN
      ,
      .lap     (lap),
      .lap_q   (lap_q)
`endif
   );

   initial clki = 1'b0;
   always #5 clki = ~clki;

   always @(posedge clki) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int m, input int s);
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [15:0] digits();
      return {min_tens, min_ones, sec_tens, sec_ones};
   endfunction

   // Monitor: every tick_o pops one expectation; stray wraps are failures
   always @(negedge clki) begin
      if (tick_o === 1'b1) begin
         n_ticks++;
         if (q_exp.size() == 0) begin
            check("unexpected_tick", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q_exp.pop_front();
            check("tick_cycle", 32'(cyc), 32'(e.due));
            check("tick_digits", 32'(digits()), 32'(e.bcd));
            check("tick_wrap", 32'(wrap_o), 32'(e.wrap));
         end
      end else if (wrap_o === 1'b1) begin
         check("stray_wrap", 32'd1, 32'd0);
      end
   end

   // One slow_i period: 5 cycles high, 5 low. Optional inc_min / clr are
   // placed in the cycle whose closing edge registers the tick.
   task automatic send_tick(input logic [15:0] exp_bcd, input logic exp_wrap,
                            input logic with_inc, input logic with_clr);
      exp_t e;
      @(negedge clki);
      slow_i = 1'b1;
      e.bcd  = exp_bcd;
      e.wrap = exp_wrap;
      e.due  = cyc + 3;
      q_exp.push_back(e);
      repeat (2) @(negedge clki);
      inc_min = with_inc;
      clr     = with_clr;
      @(negedge clki);
      inc_min = 1'b0;
      clr     = 1'b0;
      repeat (2) @(negedge clki);
      slow_i = 1'b0;
      repeat (5) @(negedge clki);
   endtask

   task automatic pulse_inc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clki);
         inc_min = 1'b1;
         @(negedge clki);
         inc_min = 1'b0;
      end
   endtask

   task automatic pulse_clr();
      @(negedge clki);
      clr = 1'b1;
      @(negedge clki);
      clr = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int t0;
      rst     = 1'b1;
      slow_i  = 1'b1;
      en      = 1'b1;
      clr     = 1'b0;
      inc_min = 1'b0;
`ifdef LAP_CAPTURE_EN
      lap     = 1'b0;
`endif

      // Reset with slow_i high, then priming must swallow the level
      repeat (3) @(negedge clki);
      check("reset_digits", 32'(digits()), 32'h0000);
      check("reset_tick", 32'(tick_o), 32'd0);
      check("reset_wrap", 32'(wrap_o), 32'd0);
      rst = 1'b0;
      t0  = n_ticks;
      repeat (10) @(negedge clki);
      check("prime_no_tick", 32'(n_ticks - t0), 32'd0);
      check("prime_digits", 32'(digits()), 32'h0000);
      slow_i = 1'b0;
      repeat (5) @(negedge clki);

      // Ten ticks -> 00:10
      for (int s = 1; s <= 10; s++) send_tick(to_bcd(0, s), 1'b0, 1'b0, 1'b0);
      check("ten_ticks", 32'(digits()), 32'h0010);

      // Seconds into minutes
      for (int s = 11; s <= 59; s++) send_tick(to_bcd(0, s), 1'b0, 1'b0, 1'b0);
      send_tick(16'h0100, 1'b0, 1'b0, 1'b0);

      // Preload 59:00, tick to 59:59, then the full wrap
      pulse_inc(58);
      check("preload_5900", 32'(digits()), 32'h5900);
      for (int s = 1; s <= 59; s++) send_tick(to_bcd(59, s), 1'b0, 1'b0, 1'b0);
      send_tick(16'h0000, 1'b1, 1'b0, 1'b0);

      // Wrap by inc_min alone: no wrap_o (monitor flags any stray pulse)
      pulse_inc(59);
      check("inc_to_5900", 32'(digits()), 32'h5900);
      pulse_inc(1);
      check("inc_wrap_0000", 32'(digits()), 32'h0000);

      // 58:59 with inc_min and tick together -> 00:00 with wrap
      for (int s = 1; s <= 59; s++) send_tick(to_bcd(0, s), 1'b0, 1'b0, 1'b0);
      pulse_inc(58);
      check("preload_5859", 32'(digits()), 32'h5859);
      send_tick(16'h0000, 1'b1, 1'b1, 1'b0);

      // clr together with a tick at 12:34
      pulse_inc(12);
      for (int s = 1; s <= 34; s++) send_tick(to_bcd(12, s), 1'b0, 1'b0, 1'b0);
      check("at_1234", 32'(digits()), 32'h1234);
      send_tick(16'h0000, 1'b0, 1'b0, 1'b1);

      // en low: digits hold at 00:03 while 20 ticks still pulse
      for (int s = 1; s <= 3; s++) send_tick(to_bcd(0, s), 1'b0, 1'b0, 1'b0);
      en = 1'b0;
      t0 = n_ticks;
      for (int i = 0; i < 20; i++) send_tick(16'h0003, 1'b0, 1'b0, 1'b0);
      check("en_low_ticks", 32'(n_ticks - t0), 32'd20);
      check("en_low_hold", 32'(digits()), 32'h0003);
      pulse_inc(1);
      check("inc_en_low", 32'(digits()), 32'h0103);

`ifdef LAP_CAPTURE_EN
      // Lap at 03:07, held through clr
      check("lap_reset", 32'(lap_q), 32'h0000);
      pulse_inc(2);
      en = 1'b1;
      for (int s = 4; s <= 7; s++) send_tick(to_bcd(3, s), 1'b0, 1'b0, 1'b0);
      @(negedge clki);
      lap = 1'b1;
      @(negedge clki);
      lap = 1'b0;
      check("lap_capture", 32'(lap_q), 32'h0307);
      pulse_clr();
      check("lap_after_clr", 32'(lap_q), 32'h0307);
      check("clr_digits", 32'(digits()), 32'h0000);
`else
      pulse_clr();
      check("clr_digits", 32'(digits()), 32'h0000);
`endif

      repeat (5) @(negedge clki);
      check("scoreboard_empty", 32'(q_exp.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bcd_mmss_counter.md
Name: bcd_mmss_counter

Overview:
- Minutes:seconds BCD time counter downstream of the clock-divider stage.
- Consumes the divider's slow square-wave output as a sampled data input, never as a clock; everything runs on the single fast clock.
- Synchronises that input, edge-detects it into one-cycle second ticks, and advances a 4-digit BCD mm:ss value for the 7-segment display stage.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on slow_i; legal 2..4.
- MIN_LIMIT, 60: minute modulus; minutes count 0..MIN_LIMIT-1; legal 2..100.

Ports:
- clki  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- slow_i  in  1  divided clock from the divider stage (level, 50% duty); treated as asynchronous data.
- en  in  1  count enable; ticks ignored while low.
- clr  in  1  synchronous clear of all digits.
- inc_min  in  1  single-cycle pulse; advance minutes by one (time-set button, already debounced).
- sec_ones  out  4  BCD 0..9.
- sec_tens  out  4  BCD 0..5.
- min_ones  out  4  BCD 0..9.
- min_tens  out  4  BCD 0..9.
- tick_o  out  1  one-cycle pulse per detected slow_i rising edge, regardless of en.
- wrap_o  out  1  one-cycle pulse when a tick rolls the count from (MIN_LIMIT-1):59 to 00:00.

Behaviour:
- Clock and reset are fixed: one clock, clki; reset is synchronous and active-high, port rst.
- Reset: all digits 0, tick_o=0, wrap_o=0, synchroniser flops 0, edge register 0, prime counter 0.
- Synchroniser: slow_i passes through SYNC_STAGES flops. An edge register holds the previous synchronised value.
- Tick: rise = synced & ~edge_reg.
  - tick_o is registered and asserts exactly SYNC_STAGES+1 cycles after the slow_i rising edge is sampled.
  - A steady-high slow_i gives no further ticks.
- Priming: a counter suppresses ticks for the first SYNC_STAGES+1 cycles after rst deasserts. slow_i already high at reset release must therefore produce no tick.
- Count step, when tick and en are both 1 in a cycle; takes effect on the next edge, same edge as tick_o:
  - sec_ones increments.
  - 9 -> 0 carries to sec_tens.
  - sec_tens 5 with sec_ones 9 -> 00 and carries one minute.
- Minutes: value m = 10*min_tens + min_ones; next value (m+k) mod MIN_LIMIT, re-encoded to BCD.
  - k = seconds carry + inc_min, range 0..2.
  - inc_min and a seconds carry in the same cycle advance minutes by 2, e.g. 58:59 -> 00:00 with MIN_LIMIT=60.
- wrap_o asserts only when a seconds carry moves minutes from MIN_LIMIT-1 to 0. A wrap caused solely by inc_min does not assert wrap_o. The double-advance case asserts wrap_o if the result passes through 0.
- inc_min acts regardless of en.
- Priority, highest first: rst > clr > count/inc_min.
  - clr zeroes digits and masks wrap_o.
  - clr does not mask tick_o and does not reset the synchroniser.
- en low: digits hold, tick_o still pulses, wrap_o stays 0.
- Digits are registered outputs and are never outside BCD range.

Optional Feature:
- Macro LAP_CAPTURE_EN.
- When defined, adds two ports:
  - input lap: single-cycle pulse.
  - output lap_q, 16 bits: {min_tens, min_ones, sec_tens, sec_ones}.
- On lap, lap_q captures the digit values present before that edge's update. It holds until the next lap. Reset value 0; clr does not affect lap_q.
- When undefined, neither port exists and behaviour is identical otherwise.

Test Plan:
- Reset and prime: hold rst 3 cycles with slow_i=1, release -> no tick_o within 10 cycles; all digits 0, wrap_o=0.
- Tick latency: SYNC_STAGES=2, slow_i toggles every 5 cycles, en=1 -> tick_o asserts 3 cycles after each slow_i rise. After 10 ticks the display reads 00:10.
- Second-to-minute carry: run to 00:59, one more tick -> 01:00; wrap_o=0.
- Full wrap: MIN_LIMIT=60, preload via inc_min to 59, tick to 59:59, one tick -> 00:00 with a single wrap_o pulse coincident with tick_o.
- Simultaneous events:
  - At 58:59, inc_min on the same cycle as a tick -> 00:00 and wrap_o=1.
  - clr on the same cycle as a tick at 12:34 -> 00:00, wrap_o=0, tick_o=1.
- en low / lap: with en=0, 20 ticks -> digits unchanged and tick_o pulses 20 times. With LAP_CAPTURE_EN, lap at 03:07 -> lap_q=16'h0307, still held after clr.
